// File: rtl/viterbi_pkg.sv
// Definitions shared by the Viterbi transmit and receive ends.
// Holds the code constants, the symbol type and the encoder FSM states.
package viterbi_pkg;

    localparam int K = 3;
    localparam logic [K-1:0] G0 = 3'b111;
    localparam logic [K-1:0] G1 = 3'b101;

    typedef logic [1:0] symbol_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } enc_state_t;

    // taps = {u, s1, s2}; the MSB of each generator multiplies the newest bit
    function automatic logic gen_parity(input logic [K-1:0] g, input logic [K-1:0] taps);
        return ^(g & taps);
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// K=3 shift register and generator XOR network.
// The symbol output is combinational; the state advances only on i_step.
module conv_enc_core
    import viterbi_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_step,
    input  logic    i_force_zero,
    input  logic    i_bit,
    output symbol_t o_sym
);

    logic r_s1;
    logic r_s2;
    logic w_u;

    assign w_u   = i_force_zero ? 1'b0 : i_bit;
    assign o_sym = {gen_parity(G0, {w_u, r_s1, r_s2}),
                    gen_parity(G1, {w_u, r_s1, r_s2})};

    // Encoder memory: shifts in the (possibly forced) input bit on each step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else if (i_step) begin
            r_s2 <= r_s1;
            r_s1 <= w_u;
        end else begin
            r_s1 <= r_s1;
            r_s2 <= r_s2;
        end
    end

endmodule

// File: rtl/conv_encoder_term.sv
// Rate-1/2 K=3 convolutional encoder with optional zero-tail termination
// after every FRAME_LEN information bits; all symbol outputs registered.
module conv_encoder_term
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = 16,
    parameter int TAIL_EN   = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    enable_i,
    input  logic    d_in,
    output logic    ready_o,
    output logic    valid_o,
    output symbol_t d_out,
    output logic    sof_o,
    output logic    eof_o
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

    enc_state_t       r_state;
    enc_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_tail_cnt;
    logic             w_tail_nxt;
    logic             w_ready;
    logic             w_accept;
    logic             w_last;
    logic             w_step;
    logic             w_force_zero;
    logic             w_sof;
    logic             w_eof;
    symbol_t          w_sym;

    logic             r_valid;
    symbol_t          r_dout;
    logic             r_sof;
    logic             r_eof;

    conv_enc_core u_core (
        .clk          (clk),
        .rst          (rst),
        .i_step       (w_step),
        .i_force_zero (w_force_zero),
        .i_bit        (d_in),
        .o_sym        (w_sym)
    );

    assign w_ready   = (r_state != TAIL);
    assign w_accept  = enable_i && w_ready;
    assign w_cnt_inc = r_bit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_last    = (w_cnt_inc == FRAME_LEN_C);

    // Next-state, counters and per-cycle symbol controls
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_bit_cnt;
        w_tail_nxt   = r_tail_cnt;
        w_step       = 1'b0;
        w_force_zero = 1'b0;
        w_sof        = 1'b0;
        w_eof        = 1'b0;
        case (r_state)
            IDLE, DATA: begin
                if (w_accept) begin
                    w_step = 1'b1;
                    w_sof  = (r_state == IDLE);
                    if (w_last) begin
                        w_cnt_nxt = {CNT_W{1'b0}};
                        if (TAIL_EN != 0) begin
                            w_state_nxt = TAIL;
                            w_tail_nxt  = 1'b0;
                        end else begin
                            // continuous stream: encoder memory carries into the next frame
                            w_eof       = 1'b1;
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                        w_state_nxt = DATA;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            TAIL: begin
                w_step       = 1'b1;
                w_force_zero = 1'b1;
                if (r_tail_cnt) begin
                    w_eof       = 1'b1;
                    w_tail_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    w_tail_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
                w_tail_nxt  = 1'b0;
            end
        endcase
    end

    // FSM state and frame counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_bit_cnt  <= {CNT_W{1'b0}};
            r_tail_cnt <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_cnt_nxt;
            r_tail_cnt <= w_tail_nxt;
        end
    end

    // Registered symbol and framing outputs; symbol is zero on idle cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_dout  <= 2'b00;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
        end else begin
            r_valid <= w_step;
            r_dout  <= w_step ? w_sym : 2'b00;
            r_sof   <= w_sof;
            r_eof   <= w_eof;
        end
    end

    assign ready_o = w_ready;
    assign valid_o = r_valid;
    assign d_out   = r_dout;
    assign sof_o   = r_sof;
    assign eof_o   = r_eof;

endmodule

// File: tb/tb_conv_encoder_term.sv
// Directed table-driven bench for conv_encoder_term: a terminated FRAME_LEN=4
// instance and a continuous FRAME_LEN=1 instance.
module tb_conv_encoder_term;

    // exp = {valid, d_out[1:0], sof, eof, ready-after-edge}
    typedef struct packed {
        logic       rst;
        logic       en;
        logic       d;
        logic [5:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic en4, d4, en1, d1;
    logic ready4, valid4, sof4, eof4;
    logic ready1, valid1, sof1, eof1;
    logic [1:0] dout4, dout1;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t tab_a[$];
    vec_t tab_b[$];

    always #5 clk = ~clk;

    conv_encoder_term #(.FRAME_LEN(4), .TAIL_EN(1)) dut4 (
        .clk(clk), .rst(rst), .enable_i(en4), .d_in(d4), .ready_o(ready4),
        .valid_o(valid4), .d_out(dout4), .sof_o(sof4), .eof_o(eof4)
    );

    conv_encoder_term #(.FRAME_LEN(1), .TAIL_EN(0)) dut1 (
        .clk(clk), .rst(rst), .enable_i(en1), .d_in(d1), .ready_o(ready1),
        .valid_o(valid1), .d_out(dout1), .sof_o(sof1), .eof_o(eof1)
    );

    task automatic check(input string name, input int idx, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got {v,dout,sof,eof,rdy}=%b expected %b", name, idx, act, exp);
        end
    endtask

    initial begin
        // Frame 1: 1,0,1,1 then two tail cycles
        tab_a.push_back({1'b0, 1'b1, 1'b1, 6'b1_11_1_0_1});
        tab_a.push_back({1'b0, 1'b1, 1'b0, 6'b1_10_0_0_1});
        tab_a.push_back({1'b0, 1'b1, 1'b1, 6'b1_00_0_0_1});
        tab_a.push_back({1'b0, 1'b1, 1'b1, 6'b1_01_0_0_0});
        tab_a.push_back({1'b0, 1'b0, 1'b0, 6'b1_01_0_0_0});
        tab_a.push_back({1'b0, 1'b0, 1'b0, 6'b1_11_0_1_1});
        // Frame 2: impulse 1,0,0,0 back-to-back
        tab_a.push_back({1'b0, 1'b1, 1'b1, 6'b1_11_1_0_1});
        tab_a.push_back({1'b0, 1'b1, 1'b0, 6'b1_10_0_0_1});
        tab_a.push_back({1'b0, 1'b1, 1'b0, 6'b1_11_0_0_1});
        tab_a.push_back({1'b0, 1'b1, 1'b0, 6'b1_00_0_0_0});
        tab_a.push_back({1'b0, 1'b0, 1'b0, 6'b1_00_0_0_0});
        tab_a.push_back({1'b0, 1'b0, 1'b0, 6'b1_00_0_1_1});
        tab_a.push_back({1'b0, 1'b0, 1'b0, 6'b0_00_0_0_1});
        // Frame 3: gapped 1,0,1,1 with d_in=1 on a disabled cycle
        tab_a.push_back({1'b0, 1'b1, 1'b1, 6'b1_11_1_0_1});
        tab_a.push_back({1'b0, 1'b0, 1'b1, 6'b0_00_0_0_1});
        tab_a.push_back({1'b0, 1'b1, 1'b0, 6'b1_10_0_0_1});
        tab_a.push_back({1'b0, 1'b0, 1'b0, 6'b0_00_0_0_1});
        tab_a.push_back({1'b0, 1'b1, 1'b1, 6'b1_00_0_0_1});
        tab_a.push_back({1'b0, 1'b0, 1'b0, 6'b0_00_0_0_1});
        tab_a.push_back({1'b0, 1'b1, 1'b1, 6'b1_01_0_0_0});
        tab_a.push_back({1'b0, 1'b0, 1'b0, 6'b1_01_0_0_0});
        tab_a.push_back({1'b0, 1'b0, 1'b0, 6'b1_11_0_1_1});
        // Frame 4: enable and d_in held high through the tail
        tab_a.push_back({1'b0, 1'b1, 1'b1, 6'b1_11_1_0_1});
        tab_a.push_back({1'b0, 1'b1, 1'b0, 6'b1_10_0_0_1});
        tab_a.push_back({1'b0, 1'b1, 1'b1, 6'b1_00_0_0_1});
        tab_a.push_back({1'b0, 1'b1, 1'b1, 6'b1_01_0_0_0});
        tab_a.push_back({1'b0, 1'b1, 1'b1, 6'b1_01_0_0_0});
        tab_a.push_back({1'b0, 1'b1, 1'b1, 6'b1_11_0_1_1});
        // Frame 5 starts at once, two bits, then reset with an accept pending
        tab_a.push_back({1'b0, 1'b1, 1'b1, 6'b1_11_1_0_1});
        tab_a.push_back({1'b0, 1'b1, 1'b0, 6'b1_10_0_0_1});
        tab_a.push_back({1'b1, 1'b1, 1'b1, 6'b0_00_0_0_1});
        tab_a.push_back({1'b0, 1'b0, 1'b0, 6'b0_00_0_0_1});
        tab_a.push_back({1'b0, 1'b0, 1'b0, 6'b0_00_0_0_1});
        // Frame 6 after reset: 1,0,1,1 reproduces the first frame
        tab_a.push_back({1'b0, 1'b1, 1'b1, 6'b1_11_1_0_1});
        tab_a.push_back({1'b0, 1'b1, 1'b0, 6'b1_10_0_0_1});
        tab_a.push_back({1'b0, 1'b1, 1'b1, 6'b1_00_0_0_1});
        tab_a.push_back({1'b0, 1'b1, 1'b1, 6'b1_01_0_0_0});
        tab_a.push_back({1'b0, 1'b0, 1'b0, 6'b1_01_0_0_0});
        tab_a.push_back({1'b0, 1'b0, 1'b0, 6'b1_11_0_1_1});

        // Continuous FRAME_LEN=1: memory carries across one-bit frames
        tab_b.push_back({1'b0, 1'b1, 1'b1, 6'b1_11_1_1_1});
        tab_b.push_back({1'b0, 1'b1, 1'b1, 6'b1_01_1_1_1});
        tab_b.push_back({1'b0, 1'b0, 1'b0, 6'b0_00_0_0_1});
        tab_b.push_back({1'b0, 1'b1, 1'b0, 6'b1_01_1_1_1});
        tab_b.push_back({1'b0, 1'b1, 1'b0, 6'b1_11_1_1_1});

        rst = 1'b1;
        en4 = 1'b1; d4 = 1'b1;
        en1 = 1'b1; d1 = 1'b1;
        @(posedge clk); #1;
        check("reset_fl4", 0, {valid4, dout4, sof4, eof4, ready4}, 6'b0_00_0_0_1);
        check("reset_fl1", 0, {valid1, dout1, sof1, eof1, ready1}, 6'b0_00_0_0_1);
        rst = 1'b0; en4 = 1'b0; d4 = 1'b0; en1 = 1'b0; d1 = 1'b0;

        for (int i = 0; i < tab_a.size(); i++) begin
            rst = tab_a[i].rst;
            en4 = tab_a[i].en;
            d4  = tab_a[i].d;
            @(posedge clk); #1;
            check("fl4_tail", i, {valid4, dout4, sof4, eof4, ready4}, tab_a[i].exp);
        end
        rst = 1'b0; en4 = 1'b0; d4 = 1'b0;

        for (int j = 0; j < tab_b.size(); j++) begin
            rst = tab_b[j].rst;
            en1 = tab_b[j].en;
            d1  = tab_b[j].d;
            @(posedge clk); #1;
            check("fl1_cont", j, {valid1, dout1, sof1, eof1, ready1}, tab_b[j].exp);
        end
        en1 = 1'b0; d1 = 1'b0;

        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
